// File: rtl/mult_div_unit_pkg.sv
// Shared MD op encodings, default latencies and decode helpers for the
// E-stage decoder and the multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    function automatic logic md_is_start(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit: computes the result at start, holds it in
// pending registers and commits to HI/LO when the busy countdown expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   count;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;

    logic               start;
    logic [31:0]        calc_hi;
    logic [31:0]        calc_lo;
    logic               calc_wr;
    logic [63:0]        prod;
    logic               div_signed;
    logic [31:0]        num_mag;
    logic [31:0]        den_mag;
    logic [31:0]        quo_mag;
    logic [31:0]        rem_mag;

    assign start = !busy && md_is_start(md_op);

    // Signed and unsigned divide share one magnitude divider; signs are
    // reapplied afterwards (INT_MIN / -1 falls out as 0x80000000 rem 0).
    always_comb begin
        calc_hi    = '0;
        calc_lo    = '0;
        calc_wr    = 1'b0;
        prod       = '0;
        quo_mag    = '0;
        rem_mag    = '0;
        div_signed = (md_op == MD_DIV);
        num_mag    = (div_signed && rs_data[31]) ? -rs_data : rs_data;
        den_mag    = (div_signed && rt_data[31]) ? -rt_data : rt_data;
        case (md_op)
            MD_MULT: begin
                prod    = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
                calc_hi = prod[63:32];
                calc_lo = prod[31:0];
                calc_wr = 1'b1;
            end
            MD_MULTU: begin
                prod    = {32'd0, rs_data} * {32'd0, rt_data};
                calc_hi = prod[63:32];
                calc_lo = prod[31:0];
                calc_wr = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                if (rt_data != '0) begin
                    quo_mag = num_mag / den_mag;
                    rem_mag = num_mag % den_mag;
                    calc_lo = (div_signed && (rs_data[31] ^ rt_data[31])) ? -quo_mag : quo_mag;
                    calc_hi = (div_signed && rs_data[31]) ? -rem_mag : rem_mag;
                    calc_wr = 1'b1;
                end
            end
            default: begin
                calc_wr = 1'b0;
            end
        endcase
    end

    always_comb begin
        md_out = '0;
        if (md_op == MD_MFHI) begin
            md_out = hi;
        end else if (md_op == MD_MFLO) begin
            md_out = lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            count   <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pend_hi <= calc_hi;
                        pend_lo <= calc_lo;
                        pend_wr <= calc_wr;
                        count   <= md_is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi <= rs_data;
                    end else if (md_op == MD_MTLO) begin
                        lo <= rs_data;
                    end
                end
                S_RUN: begin
                    if (count == CNT_W'(1)) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        count <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .busy   (busy),
        .md_out (md_out),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op   = op;
        rs_data = a;
        rt_data = b;
        tick();
        md_op = 4'd0;
    endtask

    // Counts busy cycles after a start edge, bounded so a stuck busy cannot hang.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        md_op = 4'd0; rs_data = '0; rt_data = '0;
        repeat (3) tick();
        md_op = 4'd5;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        n_cmp++; if (md_out !== 32'h0) begin n_bad++; $display("FAIL reset_md_out got=%h exp=0", md_out); end
        md_op = 4'd0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int n;
        issue(4'd1, 32'hFFFFFFFF, 32'd2);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mult_busy_start got=%b exp=1", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL mult_no_early_commit got=%h exp=0", hi); end
        wait_idle(n);
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL mult_cycles got=%0d exp=5", n); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end

        issue(4'd2, 32'hFFFFFFFF, 32'd2);
        wait_idle(n);
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL multu_cycles got=%0d exp=5", n); end
        n_cmp++; if (hi !== 32'h1) begin n_bad++; $display("FAIL multu_hi got=%h exp=1", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end

        issue(4'd1, 32'd3, 32'hFFFFFFFC);
        wait_idle(n);
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFF4) begin n_bad++; $display("FAIL mult_neg_lo got=%h exp=fffffff4", lo); end

        issue(4'd2, 32'h00010000, 32'h00010000);
        wait_idle(n);
        n_cmp++; if ({hi, lo} !== 64'h00000001_00000000) begin n_bad++; $display("FAIL multu_carry got=%h exp=0000000100000000", {hi, lo}); end
    endtask

    task automatic test_div();
        int n;
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL div_cycles got=%0d exp=10", n); end
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end

        issue(4'd4, 32'd7, 32'd2);
        wait_idle(n);
        n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL divu_cycles got=%0d exp=10", n); end
        n_cmp++; if (lo !== 32'd3) begin n_bad++; $display("FAIL divu_lo got=%h exp=3", lo); end
        n_cmp++; if (hi !== 32'd1) begin n_bad++; $display("FAIL divu_hi got=%h exp=1", hi); end

        issue(4'd3, 32'd7, 32'hFFFFFFFE);
        wait_idle(n);
        n_cmp++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin n_bad++; $display("FAIL div_negdivisor got=%h exp=00000001fffffffd", {hi, lo}); end

        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL div_intmin_lo got=%h exp=80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL div_intmin_hi got=%h exp=0", hi); end

        issue(4'd4, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        n_cmp++; if ({hi, lo} !== 64'h80000000_00000000) begin n_bad++; $display("FAIL divu_big got=%h exp=8000000000000000", {hi, lo}); end
    endtask

    task automatic test_move();
        issue(4'd7, 32'h12345678, 32'h0);
        md_op = 4'd5;
        #1;
        n_cmp++; if (md_out !== 32'h12345678) begin n_bad++; $display("FAIL mfhi got=%h exp=12345678", md_out); end
        issue(4'd8, 32'h9ABCDEF0, 32'h0);
        md_op = 4'd6;
        #1;
        n_cmp++; if (md_out !== 32'h9ABCDEF0) begin n_bad++; $display("FAIL mflo got=%h exp=9abcdef0", md_out); end
        n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL mtlo_keeps_hi got=%h exp=12345678", hi); end
        md_op = 4'd9;
        #1;
        n_cmp++; if (md_out !== 32'h0) begin n_bad++; $display("FAIL op9_md_out got=%h exp=0", md_out); end
        tick();
        n_cmp++; if ({hi, lo} !== 64'h12345678_9ABCDEF0) begin n_bad++; $display("FAIL op9_no_change got=%h exp=123456789abcdef0", {hi, lo}); end
        md_op = 4'd0;
    endtask

    task automatic test_div_zero();
        int n;
        issue(4'd7, 32'h0000AAAA, 32'h0);
        issue(4'd8, 32'h00005555, 32'h0);
        issue(4'd4, 32'd1234, 32'd0);
        md_op = 4'd5;
        #1;
        n_cmp++; if (md_out !== 32'h0000AAAA) begin n_bad++; $display("FAIL mfhi_while_busy got=%h exp=0000aaaa", md_out); end
        issue(4'd8, 32'hDEADBEEF, 32'h0);
        wait_idle(n);
        n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL divzero_remaining_cycles got=%0d exp=9", n); end
        n_cmp++; if (hi !== 32'h0000AAAA) begin n_bad++; $display("FAIL divzero_hi got=%h exp=0000aaaa", hi); end
        n_cmp++; if (lo !== 32'h00005555) begin n_bad++; $display("FAIL divzero_lo_and_busy_mtlo got=%h exp=00005555", lo); end
    endtask

    task automatic test_reset_mid();
        int n;
        issue(4'd1, 32'd3, 32'd5);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL midreset_hilo got=%h exp=0", {hi, lo}); end
        repeat (8) tick();
        n = 0;
        n_cmp++; if ({busy, hi, lo} !== 65'h0) begin n_bad++; $display("FAIL midreset_no_commit got=%h exp=0", {busy, hi, lo}); end
    endtask

    task automatic test_back_to_back();
        int n;
        md_op   = 4'd1;
        rs_data = 32'd3;
        rt_data = 32'd5;
        tick();
        rs_data = 32'd100;
        wait_idle(n);
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL held_cycles got=%0d exp=5", n); end
        n_cmp++; if ({hi, lo} !== 64'd15) begin n_bad++; $display("FAIL held_single_result got=%h exp=f", {hi, lo}); end
        tick();
        md_op = 4'd0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        wait_idle(n);
        n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL b2b_cycles got=%0d exp=5", n); end
        n_cmp++; if ({hi, lo} !== 64'd500) begin n_bad++; $display("FAIL b2b_result got=%h exp=1f4", {hi, lo}); end
    endtask

    initial begin
        reset   = 1'b0;
        md_op   = 4'd0;
        rs_data = '0;
        rt_data = '0;
        #2;
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
